// File: rtl/id_stage_gen2.sv
// id_stage_gen2 -- MIPS decode stage, second generation.
// Contains the register file with a write-back to decode bypass, the control
// decode, load-use and branch hazard detection, branch resolution, and the
// registered ID/EX pipeline outputs.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   if_valid, inst_in,   instruction and its PC+4 from the IF/ID register
//   pc
//   wb_we, wb_addr,      register file write port, driven by WB
//   wb_data
//   ex_reg_write,        EX-stage instruction info for hazard detection
//   ex_mem_read, ex_dst
//   mem_mem_read,        MEM-stage load info for branch hazard detection
//   mem_dst
//   hold_pc, hold_if     freeze PC and IF/ID register (combinational)
//   flush_if             squash IF/ID register on the next edge (combinational)
//   br_taken, pc_branch  branch resolution and target (combinational)
//   id_valid, illegal    ID/EX valid bit and unknown-opcode flag
//   ex_ctrl              {RegDst, ALUOp[1:0], ALUSrc}
//   m_ctrl               {Branch, MemRead, MemWrite}
//   wb_ctrl              {RegWrite, MemtoReg}
//   rs, rt, rd, imm,     registered register indices, sign-extended
//   data_1, data_2       immediate and register read data
module id_stage_gen2 #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned RA  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_we,
  input  logic [RA-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic [RA-1:0]   ex_dst,
  input  logic            mem_mem_read,
  input  logic [RA-1:0]   mem_dst,
  output logic            hold_pc,
  output logic            hold_if,
  output logic            flush_if,
  output logic            br_taken,
  output logic [XLEN-1:0] pc_branch,
  output logic            id_valid,
  output logic            illegal,
  output logic [3:0]      ex_ctrl,
  output logic [2:0]      m_ctrl,
  output logic [1:0]      wb_ctrl,
  output logic [RA-1:0]   rs,
  output logic [RA-1:0]   rt,
  output logic [RA-1:0]   rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] data_1,
  output logic [XLEN-1:0] data_2
);

  logic [XLEN-1:0] regs [NREG];

  logic [5:0]      opcode;
  logic [RA-1:0]   rs_idx, rt_idx, rd_idx;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] rdata_1, rdata_2;

  logic [3:0] dec_ex;
  logic [2:0] dec_m;
  logic [1:0] dec_wb;
  logic       dec_illegal;
  logic       uses_rt;
  logic       is_beq, is_bne, is_branch;

  logic ex_hit, mem_hit, stall, load;

  assign opcode   = inst_in[31:26];
  // Index fields are narrowed (or widened) to the register-file index width.
  assign rs_idx   = RA'(inst_in[25:21]);
  assign rt_idx   = RA'(inst_in[20:16]);
  assign rd_idx   = RA'(inst_in[15:11]);
  assign imm_sext = {{(XLEN-16){inst_in[15]}}, inst_in[15:0]};

  // Register file: entry 0 is never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back is forwarded so decode never sees a stale value.
  always_comb begin
    rdata_1 = '0;
    rdata_2 = '0;
    if (rs_idx != '0) rdata_1 = (wb_we && wb_addr == rs_idx) ? wb_data : regs[rs_idx];
    if (rt_idx != '0) rdata_2 = (wb_we && wb_addr == rt_idx) ? wb_data : regs[rt_idx];
  end

  always_comb begin
    dec_ex      = '0;
    dec_m       = '0;
    dec_wb      = '0;
    dec_illegal = 1'b1;
    uses_rt     = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    unique case (opcode)
      6'b000000: begin
        dec_ex = 4'b1100; dec_wb = 2'b10;
        uses_rt = 1'b1; dec_illegal = 1'b0;
      end
      6'b100011: begin
        dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11;
        dec_illegal = 1'b0;
      end
      6'b101011: begin
        dec_ex = 4'b0001; dec_m = 3'b001;
        uses_rt = 1'b1; dec_illegal = 1'b0;
      end
      6'b000100: begin
        dec_ex = 4'b0010; dec_m = 3'b100;
        uses_rt = 1'b1; is_beq = 1'b1; dec_illegal = 1'b0;
      end
      6'b000101: begin
        dec_ex = 4'b0010; dec_m = 3'b100;
        uses_rt = 1'b1; is_bne = 1'b1; dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign is_branch = is_beq | is_bne;

  // A source only counts as a hazard if it is actually read by this opcode.
  assign ex_hit  = (ex_dst != '0) &&
                   ((ex_dst == rs_idx) || (uses_rt && ex_dst == rt_idx));
  assign mem_hit = (mem_dst != '0) &&
                   ((mem_dst == rs_idx) || (uses_rt && mem_dst == rt_idx));

  // Branches compare in ID, so they also wait on ALU results in EX and on
  // loads still in MEM.
  assign stall = if_valid &&
                 ((ex_mem_read && ex_hit) ||
                  (is_branch && ex_reg_write && ex_hit) ||
                  (is_branch && mem_mem_read && mem_hit));

  assign load = if_valid && !stall;

  assign hold_pc   = rst_n && stall;
  assign hold_if   = rst_n && stall;
  assign br_taken  = rst_n && load && is_branch &&
                     (is_beq ? (rdata_1 == rdata_2) : (rdata_1 != rdata_2));
  assign flush_if  = br_taken;
  assign pc_branch = pc + (imm_sext << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      illegal  <= 1'b0;
      ex_ctrl  <= '0;
      m_ctrl   <= '0;
      wb_ctrl  <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      imm      <= '0;
      data_1   <= '0;
      data_2   <= '0;
    end else if (load) begin
      id_valid <= 1'b1;
      illegal  <= dec_illegal;
      ex_ctrl  <= dec_ex;
      m_ctrl   <= dec_m;
      wb_ctrl  <= dec_wb;
      rs       <= rs_idx;
      rt       <= rt_idx;
      rd       <= rd_idx;
      imm      <= imm_sext;
      data_1   <= rdata_1;
      data_2   <= rdata_2;
    end else begin
      // Bubble: nothing downstream may act on this slot.
      id_valid <= 1'b0;
      illegal  <= 1'b0;
      ex_ctrl  <= '0;
      m_ctrl   <= '0;
      wb_ctrl  <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      imm      <= '0;
      data_1   <= '0;
      data_2   <= '0;
    end
  end

endmodule

// File: tb/tb_id_stage_gen2.sv
// Testbench for id_stage_gen2: a table of hand-derived vectors, random
// stimulus against a behavioural model, and a reset-during-stall sequence.
module tb_id_stage_gen2;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] inst_in;
  logic [31:0] pc;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_dst;
  logic        mem_mem_read;
  logic [4:0]  mem_dst;
  logic        hold_pc, hold_if, flush_if, br_taken;
  logic [31:0] pc_branch;
  logic        id_valid, illegal;
  logic [3:0]  ex_ctrl;
  logic [2:0]  m_ctrl;
  logic [1:0]  wb_ctrl;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, data_1, data_2;

  id_stage_gen2 #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .inst_in(inst_in), .pc(pc),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .hold_pc(hold_pc), .hold_if(hold_if), .flush_if(flush_if),
    .br_taken(br_taken), .pc_branch(pc_branch), .id_valid(id_valid),
    .illegal(illegal), .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .data_1(data_1), .data_2(data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        exrw;
    logic        exmr;
    logic [4:0]  exd;
    logic        mmr;
    logic [4:0]  md;
  } in_t;

  typedef struct {
    logic        hold;
    logic        br;
    logic [31:0] pcb;
    logic        v;
    logic        ill;
    logic [8:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [14:0] idx;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
    bit   chk_pcb;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int step     = 0;

  logic [31:0] mregs [32];

  localparam logic [8:0] C_R   = 9'b1100_000_10;
  localparam logic [8:0] C_LW  = 9'b0001_010_11;
  localparam logic [8:0] C_SW  = 9'b0001_001_00;
  localparam logic [8:0] C_BR  = 9'b0010_100_00;
  localparam logic [8:0] C_NONE = 9'b0;

  function automatic logic [31:0] r_ins(logic [4:0] s, logic [4:0] t, logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] s, logic [4:0] t,
                                        logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic in_t mi(logic iv, logic [31:0] inst, logic [31:0] pcv,
                             logic we, logic [4:0] wa, logic [31:0] wd,
                             logic exrw, logic exmr, logic [4:0] exd,
                             logic mmr, logic [4:0] md);
    in_t r;
    r.iv = iv; r.inst = inst; r.pc = pcv; r.we = we; r.wa = wa; r.wd = wd;
    r.exrw = exrw; r.exmr = exmr; r.exd = exd; r.mmr = mmr; r.md = md;
    return r;
  endfunction

  function automatic vec_t mkv(in_t i, logic hold, logic br, logic [31:0] pcb, bit chkp,
                               logic v, logic ill, logic [8:0] ctrl,
                               logic [31:0] d1, logic [31:0] d2);
    vec_t r;
    r.i = i;
    r.e.hold = hold; r.e.br = br; r.e.pcb = pcb; r.e.v = v; r.e.ill = ill;
    r.e.ctrl = ctrl; r.e.d1 = d1; r.e.d2 = d2; r.e.imm = 32'd0; r.e.idx = 15'd0;
    r.chk_pcb = chkp;
    return r;
  endfunction

  // Reference model: register read with same-cycle write visibility, then
  // the opcode table, hazard rules and branch outcome.
  function automatic logic [31:0] read_reg(in_t i, logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (i.we && i.wa == idx) return i.wd;
    return mregs[idx];
  endfunction

  function automatic exp_t model(in_t i);
    exp_t e;
    logic [5:0]  op = i.inst[31:26];
    logic [4:0]  s  = i.inst[25:21];
    logic [4:0]  t  = i.inst[20:16];
    logic [4:0]  d  = i.inst[15:11];
    logic signed [31:0] off = $signed(i.inst[15:0]);
    logic [31:0] a, b;
    logic [8:0]  ctrl;
    bit legal, br, rd_t, ex_h, mem_h, stall, go;
    case (op)
      6'h00:   begin ctrl = C_R;  legal = 1; br = 0; rd_t = 1; end
      6'h23:   begin ctrl = C_LW; legal = 1; br = 0; rd_t = 0; end
      6'h2b:   begin ctrl = C_SW; legal = 1; br = 0; rd_t = 1; end
      6'h04,
      6'h05:   begin ctrl = C_BR; legal = 1; br = 1; rd_t = 1; end
      default: begin ctrl = C_NONE; legal = 0; br = 0; rd_t = 0; end
    endcase
    a = read_reg(i, s);
    b = read_reg(i, t);
    ex_h  = (i.exd != 5'd0) && (i.exd == s || (rd_t && i.exd == t));
    mem_h = (i.md  != 5'd0) && (i.md  == s || (rd_t && i.md  == t));
    stall = i.iv && ((i.exmr && ex_h) || (br && i.exrw && ex_h) || (br && i.mmr && mem_h));
    go    = i.iv && !stall;
    e.hold = stall;
    e.br   = go && br && ((op == 6'h04) ? (a == b) : (a != b));
    e.pcb  = i.pc + $unsigned(off * 32'sd4);
    e.v    = go;
    e.ill  = go && !legal;
    e.ctrl = go ? ctrl : C_NONE;
    e.d1   = go ? a : 32'd0;
    e.d2   = go ? b : 32'd0;
    e.imm  = go ? $unsigned(off) : 32'd0;
    e.idx  = go ? {s, t, d} : 15'd0;
    return e;
  endfunction

  task automatic chk1(string nm, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %b expected %b", nm, step, act, exp);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, step, act, exp);
    end
  endtask

  task automatic drive(in_t i);
    if_valid = i.iv; inst_in = i.inst; pc = i.pc;
    wb_we = i.we; wb_addr = i.wa; wb_data = i.wd;
    ex_reg_write = i.exrw; ex_mem_read = i.exmr; ex_dst = i.exd;
    mem_mem_read = i.mmr; mem_dst = i.md;
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic run_cycle(vec_t v, bit chk_ext);
    drive(v.i);
    #2;
    chk1("hold_pc", hold_pc, v.e.hold);
    chk1("hold_if", hold_if, v.e.hold);
    chk1("br_taken", br_taken, v.e.br);
    chk1("flush_if", flush_if, v.e.br);
    if (v.chk_pcb) chk("pc_branch", pc_branch, v.e.pcb);
    @(posedge clk);
    #1;
    chk1("id_valid", id_valid, v.e.v);
    chk1("illegal", illegal, v.e.ill);
    chk("ctrl", 32'({ex_ctrl, m_ctrl, wb_ctrl}), 32'(v.e.ctrl));
    chk("data_1", data_1, v.e.d1);
    chk("data_2", data_2, v.e.d2);
    if (chk_ext) begin
      chk("imm", imm, v.e.imm);
      chk("rs_rt_rd", 32'({rs, rt, rd}), 32'(v.e.idx));
    end
    if (v.i.we && v.i.wa != 5'd0) mregs[v.i.wa] = v.i.wd;
    step++;
  endtask

  vec_t tbl[$];
  localparam logic [31:0] P  = 32'h0000_0100;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] AA = 32'hAAAA_0001;

  initial begin
    in_t  s;
    vec_t v;

    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
    rst_n = 1'b0;
    drive(mi(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0));
    @(posedge clk); @(posedge clk); #1;
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_ctrl", 32'({ex_ctrl, m_ctrl, wb_ctrl}), 32'd0);
    chk("rst_data_1", data_1, 32'd0);
    chk1("rst_hold_pc", hold_pc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-derived vectors; register state carries from row to row.
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd5, 5'd0, 5'd7), P, 1'b1, 5'd5, DB, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, DB, 32'd0));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd5, 5'd0, 5'd7), P, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, DB, 32'd0));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd0, 5'd5, 5'd7), P, 1'b1, 5'd1, AA, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, 32'd0, DB));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h23, 5'd1, 5'd9, 16'h0004), P, 1'b1, 5'd2, AA, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_LW, AA, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b1, 32'h0000_00FC, 1'b1, 1'b1, 1'b0, C_BR, AA, AA));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h05, 5'd1, 5'd2, 16'hFFFF), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'h0000_00FC, 1'b1, 1'b1, 1'b0, C_BR, AA, AA));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd3, 5'd0, 5'd7), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0),
                      1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd3, 5'd0, 5'd7), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h3F, 5'd0, 5'd0, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b0, r_ins(5'd1, 5'd2, 5'd7), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'h0010), P, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd2, 1'b0, 5'd0),
                      1'b1, 1'b0, 32'h0000_0140, 1'b1, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'h0010), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b1, 32'h0000_0140, 1'b1, 1'b1, 1'b0, C_BR, AA, AA));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h05, 5'd1, 5'd2, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1),
                      1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd0, 5'd0, 5'd7), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h2b, 5'd0, 5'd9, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0),
                      1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h23, 5'd0, 5'd9, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_LW, 32'd0, 32'd0));
    tbl.push_back(mkv(mi(1'b1, r_ins(5'd1, 5'd0, 5'd7), P, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, C_R, AA, 32'd0));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h04, 5'd2, 5'd1, 16'h0000), P, 1'b1, 5'd2, 32'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, P, 1'b1, 1'b1, 1'b0, C_BR, 32'd5, AA));
    tbl.push_back(mkv(mi(1'b1, i_ins(6'h05, 5'd2, 5'd1, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b1, P, 1'b1, 1'b1, 1'b0, C_BR, 32'd5, AA));
    tbl.push_back(mkv(mi(1'b0, i_ins(6'h02, 5'd0, 5'd0, 16'h0000), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0),
                      1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 32'd0));

    for (int k = 0; k < tbl.size(); k++) run_cycle(tbl[k], 1'b0);

    // Random stimulus against the model; small index range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h2b;
        3:       op = 6'h04;
        4:       op = 6'h05;
        default: op = 6'($urandom);
      endcase
      s.inst = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      s.iv   = ($urandom_range(0, 7) != 0);
      s.pc   = $urandom;
      s.we   = 1'($urandom);
      s.wa   = 5'($urandom_range(0, 7));
      s.wd   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      s.exrw = 1'($urandom);
      s.exmr = ($urandom_range(0, 3) == 0);
      s.exd  = 5'($urandom_range(0, 7));
      s.mmr  = ($urandom_range(0, 3) == 0);
      s.md   = 5'($urandom_range(0, 7));
      v.i = s;
      v.e = model(s);
      v.chk_pcb = 1'b1;
      run_cycle(v, 1'b1);
    end

    // Reset asserted mid-cycle while a load-use stall is pending.
    s = mi(1'b1, r_ins(5'd5, 5'd0, 5'd0), P, 1'b1, 5'd5, DB, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    v.i = s; v.e = model(s); v.chk_pcb = 1'b1;
    run_cycle(v, 1'b1);
    s = mi(1'b1, r_ins(5'd5, 5'd6, 5'd0), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
    drive(s);
    #2;
    chk1("pre_rst_hold", hold_pc, 1'b1);
    chk("pre_rst_data_1", data_1, DB);
    rst_n = 1'b0;
    #1;
    chk1("rst_async_hold_pc", hold_pc, 1'b0);
    chk1("rst_async_hold_if", hold_if, 1'b0);
    chk1("rst_async_id_valid", id_valid, 1'b0);
    chk("rst_async_data_1", data_1, 32'd0);
    chk("rst_async_ctrl", 32'({ex_ctrl, m_ctrl, wb_ctrl}), 32'd0);
    s = mi(1'b1, i_ins(6'h04, 5'd0, 5'd0, 16'h0001), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(s);
    #1;
    chk1("rst_br_taken", br_taken, 1'b0);
    chk1("rst_flush_if", flush_if, 1'b0);
    @(posedge clk); #1;
    chk1("rst_edge_id_valid", id_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
    s = mi(1'b1, r_ins(5'd5, 5'd6, 5'd0), P, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    v.i = s; v.e = model(s); v.chk_pcb = 1'b1;
    run_cycle(v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
